uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  baud-rate clock; all state changes on its rising edge.
REQ-002 SHALL have port: rest  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: data_valid  input  1  one-cycle request to send p_data.
REQ-004 SHALL have port: p_data  input  8  parallel byte to send.
REQ-005 SHALL have port: par_typ  input  1  0 = even parity, 1 = odd parity; exists only with UART_TX_PARITY_EN.
REQ-006 SHALL have port: ser_data  input  1  serialized data bit from the serializer stage.
REQ-007 SHALL have port: ser_done  input  1  serializer completion flag; monitored only, never used for transitions.
REQ-008 SHALL have port: ser_en  output  1  serializer shift enable.
REQ-009 SHALL have port: tx_out  output  1  UART line; idle and stop level is high.
REQ-010 SHALL have port: busy  output  1  frame in progress.

Function
REQ-011 SHALL implement the states IDLE, START, DATA, PARITY and STOP; each state except DATA lasts exactly 1 clk.
REQ-012 In IDLE, data_valid=1 SHALL transition to START on the next edge.
REQ-013 On that edge, the block SHALL latch par_typ and the parity of p_data.
REQ-014 START SHALL always transition to DATA.
REQ-015 DATA SHALL last exactly 8 clk, counted by an internal 3-bit bit counter cleared on entry.
REQ-016 DATA SHALL exit when the bit counter equals 7: to PARITY when parity is compiled in, otherwise to STOP.
REQ-017 PARITY SHALL always transition to STOP.
REQ-018 In STOP, data_valid=1 SHALL transition directly to START with a new parity latch; otherwise STOP SHALL transition to IDLE.
REQ-019 data_valid asserted in START, DATA or PARITY SHALL be ignored; no queueing.
REQ-020 tx_out SHALL be a combinational decode of state: IDLE=1, START=0, DATA=ser_data, PARITY=latched parity bit, STOP=1.
REQ-021 ser_en SHALL be 1 exactly while in DATA.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 Parity SHALL be even = XOR of the 8 bits when par_typ=0, and odd = XNOR of the 8 bits when par_typ=1.
REQ-024 Frame timing SHALL be: data_valid sampled at edge E; start bit during cycle E+1; data bits LSB-first in cycles E+2..E+9; parity bit in cycle E+10; stop bit in cycle E+11; back in IDLE at E+12 if no new request.
REQ-025 The bit counter SHALL wrap from 7 to 0 and SHALL be cleared on every DATA entry.

Reset
REQ-026 Asserting rest SHALL immediately force state=IDLE, bit counter=0 and latched parity=0.
REQ-027 While rest is asserted, outputs SHALL be tx_out=1, ser_en=0 and busy=0.
REQ-028 rest asserted mid-frame SHALL abort the frame immediately, with the line returning high and no partial stop bit.
REQ-029 After rest deasserts, the first edge SHALL evaluate the IDLE transitions.

Configuration
REQ-030 With UART_TX_PARITY_EN defined, the PARITY state, the par_typ port and the parity latch SHALL exist, giving a frame length of 11 clk.
REQ-031 Without UART_TX_PARITY_EN, the PARITY state, the par_typ port and the parity latch SHALL be removed, giving a frame length of 10 clk; all other behaviour SHALL be unchanged.

Verification
REQ-032 Parity enabled, p_data=8'hA5, par_typ=0, ser_data driven LSB-first -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 then idle high; busy high for 11 cycles.
REQ-033 Parity enabled, p_data=8'h07, par_typ=1 -> parity bit 0 (three ones; odd parity requires a 0 to keep the total odd); p_data=8'h00, par_typ=1 -> parity bit 1.
REQ-034 Back-to-back: second data_valid pulse applied during STOP -> START follows STOP directly with no idle cycle and busy stays 1; a pulse applied during DATA is dropped.
REQ-035 rest asserted at the 4th DATA cycle -> tx_out=1, busy=0, ser_en=0 asynchronously; the next data_valid produces a full, correct frame.
REQ-036 Parity disabled, p_data=8'hFF -> tx_out 0, then eight 1s, then stop 1; busy high for exactly 10 cycles; ser_en high for exactly 8 cycles.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   Frame controller for a UART transmitter. It sequences
//   START -> DATA (8 bits) -> [PARITY] -> STOP and drives the line from the
//   current state. The bit values come from an external serializer through
//   ser_data, and this block enables that serializer with ser_en.
//
//   Optional feature: define UART_TX_PARITY_EN to add the PARITY state, the
//   par_typ port and the parity latch. The frame is then 11 clk long. In the
//   default build the frame is 10 clk long.
//
// Ports
//   clk        in   baud-rate clock, rising edge
//   rest       in   asynchronous active-high reset
//   data_valid in   one-cycle request to send p_data (honoured in IDLE/STOP)
//   p_data     in   [7:0] byte to send
//   par_typ    in   0 = even, 1 = odd parity (UART_TX_PARITY_EN only)
//   ser_data   in   current serialized data bit
//   ser_done   in   serializer completion flag (observed only)
//   ser_en     out  serializer shift enable, high for the 8 DATA cycles
//   tx_out     out  UART line, idle/stop high
//   busy       out  high whenever a frame is in progress
// ---------------------------------------------------------------------------
module uart_tx_ctrl (
  input  logic       clk,
  input  logic       rest,
  input  logic       data_valid,
  input  logic [7:0] p_data,
`ifdef UART_TX_PARITY_EN
  input  logic       par_typ,
`endif
  input  logic       ser_data,
  input  logic       ser_done,
  output logic       ser_en,
  output logic       tx_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] bit_cnt_reg;

  // ser_done is informational only. The frame length is fixed by the bit
  // counter, so this flag is never used for a transition.
  logic       unused_ser_done;
  assign unused_ser_done = ser_done;

  // A new frame is accepted only in IDLE or STOP. This makes back-to-back
  // frames possible with no idle gap between them.
  logic       accept;
  assign accept = data_valid && ((state_reg == IDLE) || (state_reg == STOP));

  // State register
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   state_next = data_valid ? START : IDLE;
      START:  state_next = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   state_next = (bit_cnt_reg == 3'd7) ? PARITY : DATA;
      PARITY: state_next = STOP;
`else
      DATA:   state_next = (bit_cnt_reg == 3'd7) ? STOP : DATA;
`endif
      STOP:   state_next = data_valid ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit counter. It is held at zero outside DATA, so it is always clear on
  // entry to DATA. It counts 0..7 and then wraps.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      bit_cnt_reg <= 3'd0;
    end else if (state_reg == DATA) begin
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
    end else begin
      bit_cnt_reg <= 3'd0;
    end
  end

`ifdef UART_TX_PARITY_EN
  // The parity bit is captured together with the request. p_data and
  // par_typ only need to be valid on the accepting edge.
  logic par_bit_reg;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      par_bit_reg <= 1'b0;
    end else if (accept) begin
      par_bit_reg <= par_typ ? ~(^p_data) : (^p_data);
    end
  end
`else
  // Without parity, p_data is carried by the external serializer only.
  logic       unused_accept;
  logic [7:0] unused_p_data;
  assign unused_accept = accept;
  assign unused_p_data = p_data;
`endif

  // Output decode
  always_comb begin
    tx_out = 1'b1;
    ser_en = 1'b0;
    busy   = 1'b1;
    case (state_reg)
      IDLE:   busy   = 1'b0;
      START:  tx_out = 1'b0;
      DATA: begin
        tx_out = ser_data;
        ser_en = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: tx_out = par_bit_reg;
`endif
      STOP:   tx_out = 1'b1;
      default: begin
        tx_out = 1'b1;
        busy   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Self-checking bench for uart_tx_ctrl. It works with or without
//   UART_TX_PARITY_EN.
//
//   The reference model tracks only the position inside the frame
//   (0 = idle, 1 = start, 2..9 = data, then optional parity, then stop).
//   It derives the expected line level, busy and ser_en from that position,
//   the accepted byte and a parity bit computed from $countones. The bench
//   also acts as the serializer: it presents the correct data bit on
//   ser_data during data cycles and random noise at all other times.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  logic       clk;
  logic       rest;
  logic       data_valid;
  logic [7:0] p_data;
  logic       par_typ;
  logic       ser_data;
  logic       ser_done;
  logic       ser_en;
  logic       tx_out;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         pos    = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_par  = 1'b0;

  uart_tx_ctrl dut (
    .clk        (clk),
    .rest       (rest),
    .data_valid (data_valid),
    .p_data     (p_data),
`ifdef UART_TX_PARITY_EN
    .par_typ    (par_typ),
`endif
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .ser_en     (ser_en),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s pos=%0d got=%0h exp=%0h t=%0t", tag, pos, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    logic [7:0] b;
    b = m_byte;
    if (pos == 0) return 1'b1;
    if (pos == 1) return 1'b0;
    if (pos >= 2 && pos <= 9) return b[pos-2];
`ifdef UART_TX_PARITY_EN
    if (pos == 10) return m_par;
`endif
    return 1'b1;
  endfunction

  task automatic check_outputs(input string where);
    check_eq({where, "_tx_out"}, {31'd0, tx_out}, {31'd0, exp_tx()});
    check_eq({where, "_busy"},   {31'd0, busy},   {31'd0, (pos != 0)});
    check_eq({where, "_ser_en"}, {31'd0, ser_en}, {31'd0, (pos >= 2 && pos <= 9)});
  endtask

  // Presents the serializer bit for the current frame position
  task automatic drive_ser();
    logic [7:0] b;
    b = m_byte;
    if (pos >= 2 && pos <= 9) ser_data = b[pos-2];
    else                      ser_data = 1'($urandom_range(0, 1));
    ser_done = 1'($urandom_range(0, 1));
  endtask

  // One clock cycle: check the outputs, apply the inputs, then advance the model
  task automatic step(input logic dv, input logic [7:0] b, input logic pt);
    @(negedge clk);
    drive_ser();
    #1;
    check_outputs("cyc");
    data_valid = dv;
    p_data     = b;
    par_typ    = pt;
    @(posedge clk);
    if (pos == 0 || pos == FRAME_LEN) begin
      if (dv) begin
        pos    = 1;
        m_byte = b;
        // Odd parity: the total count of ones must be odd. Even parity:
        // the total count must be even.
        m_par  = pt ? (($countones(b) % 2) == 0) : (($countones(b) % 2) == 1);
        $display("frame start byte=%02h par_typ=%0d t=%0t", b, pt, $time);
      end else begin
        pos = 0;
      end
    end else begin
      pos = pos + 1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pt);
    step(1'b1, b, pt);
    repeat (FRAME_LEN) step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // Asserts rest in the middle of the current cycle and checks that the
  // outputs go idle at once, without waiting for a clock edge.
  task automatic mid_reset();
    @(negedge clk);
    drive_ser();
    #1;
    check_outputs("pre_rst");
    data_valid = 1'b0;
    #1;
    rest = 1'b1;
    #1;
    pos = 0;
    check_outputs("async_rst");
    @(negedge clk);
    #1;
    check_outputs("held_rst");
    rest = 1'b0;
    $display("reset pulse applied t=%0t", $time);
  endtask

  initial begin
    rest       = 1'b1;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_typ    = 1'b0;
    ser_data   = 1'b0;
    ser_done   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_outputs("reset");
    rest = 1'b0;

    // Directed frames
    send_frame(8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    send_frame(8'h07, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b0);

    // Back-to-back. A pulse at position 4 (DATA) must be dropped. A pulse
    // at the stop position must start the next frame with no idle gap.
    step(1'b1, 8'h3C, 1'b0);
    for (int k = 1; k < FRAME_LEN; k++) step(k == 4, 8'h99, 1'b1);
    step(1'b1, 8'hC3, 1'b1);
    repeat (FRAME_LEN + 1) step(1'b0, 8'h00, 1'b0);

    // Reset during the 4th DATA cycle (position 5), then a full frame
    step(1'b1, 8'h5A, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0);
    mid_reset();
    send_frame(8'h5A, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) mid_reset();
      else step($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (FRAME_LEN + 2) step(1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
